// File: rtl/shifter_iter_pkg.sv
// Shared definitions for the iterative shifter and the ALU decode that issues to it.
// Holds default data/count widths, the 2-bit op encoding and the 2-bit FSM state encoding.
// Op encoding: bit 0 selects shift (1) vs rotate (0), bit 1 selects right (1) vs left (0).
package shifter_iter_pkg;

    // Default datapath geometry: WIDTH must be a power of two, CNT_W = log2(WIDTH).
    localparam int SHIFT_WIDTH = 16;
    localparam int SHIFT_CNT_W = 4;

    // Operation codes, shared with ALU decode.
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // True for the zero-filling variants (SLL/SRL), false for rotates.
    function automatic logic op_is_logical(input logic [1:0] op);
        return op[0];
    endfunction

    // True for right-going variants (ROR/SRL).
    function automatic logic op_is_right(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/shifter_iter_shift_stage_var.sv
// One binary-weighted shift/rotate stage: shifts data_i by 2^k_i using op_i.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller decides when the result is captured.
//
// Ports:
//   data_i  operand
//   op_i    operation code (ROL/SLL/ROR/SRL)
//   k_i     stage index; shift amount is 1 << k_i
//   data_o  shifted / rotated operand
module shift_stage_var
    import shifter_iter_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int K_W   = 2
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic [K_W-1:0]   k_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(WIDTH);

    logic [AW-1:0]        amt;
    logic [2*WIDTH-1:0]   dbl;
    logic [2*WIDTH-1:0]   dbl_l;
    logic [2*WIDTH-1:0]   dbl_r;
    logic [WIDTH-1:0]     rol_v;
    logic [WIDTH-1:0]     ror_v;
    logic [WIDTH-1:0]     sll_v;
    logic [WIDTH-1:0]     srl_v;

    // Largest stage is WIDTH/2, which always fits in AW bits.
    assign amt = AW'(1) << k_i;

    // Rotates come from a doubled operand: bits pushed out of one copy are
    // refilled from the other, so a plain shift of the pair is a rotate.
    assign dbl   = {data_i, data_i};
    assign dbl_l = dbl << amt;
    assign dbl_r = dbl >> amt;

    assign rol_v = dbl_l[2*WIDTH-1:WIDTH];
    assign ror_v = dbl_r[WIDTH-1:0];
    assign sll_v = data_i << amt;
    assign srl_v = data_i >> amt;

    always_comb begin
        data_o = rol_v;
        if (op_is_right(op_i)) begin
            data_o = op_is_logical(op_i) ? srl_v : ror_v;
        end else begin
            data_o = op_is_logical(op_i) ? sll_v : rol_v;
        end
    end

endmodule

// File: rtl/shifter_iter.sv
// Multi-cycle shifter/rotator: one binary-weighted stage (1,2,4,...) resolved per clock.
// Latency: CNT_W cycles from accept edge to out_valid, independent of Cnt.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  request handshake (In, Cnt, Op captured on accept)
//   In, Cnt, Op          operand, shift amount, operation code
//   out_valid/out_ready  result handshake
//   Out                  registered result; keeps last value after transfer
module shifter_iter
    import shifter_iter_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out
);

    // Stage index needs to address CNT_W stages.
    localparam int             K_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(CNT_W - 1);

    logic [1:0]       state_q, state_d;
    logic [K_W-1:0]   k_q,     k_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] data_q,  data_d;

    logic [WIDTH-1:0] stage_out;

    // Single stage datapath, reused every SHIFT cycle with a different k.
    shift_stage_var #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_stage (
        .data_i (data_q),
        .op_i   (op_q),
        .k_i    (k_q),
        .data_o (stage_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SHIFT;
                    data_d  = In;
                    cnt_d   = Cnt;
                    op_d    = Op;
                    k_d     = '0;
                end
            end

            ST_SHIFT: begin
                // Stage k contributes only if bit k of the count is set; the
                // cycle is spent either way so latency never depends on Cnt.
                if (cnt_q[k_q]) begin
                    data_d = stage_out;
                end
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            ST_DONE: begin
                // No DONE->SHIFT bypass: a new request is taken from IDLE only.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    // Out is not cleared on transfer; consumers qualify it with out_valid.
    assign Out       = data_q;

endmodule

// File: tb/tb_shifter_iter.sv
module tb_shifter_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out;

    int n_cmp;
    int n_fail;
    int busy_err;

    localparam logic [1:0] T_ROL = 2'b00;
    localparam logic [1:0] T_SLL = 2'b01;
    localparam logic [1:0] T_ROR = 2'b10;
    localparam logic [1:0] T_SRL = 2'b11;

    shifter_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Cnt       (Cnt),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [3:0]  c;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-count shift/rotate done one bit at a time.
    function automatic logic [15:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                              input logic [3:0] c);
        logic [15:0] r;
        r = a;
        case (op)
            T_SLL: r = a << c;
            T_SRL: r = a >> c;
            T_ROL: for (int i = 0; i < int'(c); i++) r = {r[14:0], r[15]};
            default: for (int i = 0; i < int'(c); i++) r = {r[0], r[15:1]};
        endcase
        return r;
    endfunction

    // Issue one request, wait for out_valid; inputs are scrambled right after accept.
    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [3:0] c,
                         output logic [15:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_ready", 32'(in_ready), 32'd1);
        In       = a;
        Cnt      = c;
        Op       = op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        In       = 16'($urandom);
        Cnt      = 4'($urandom);
        Op       = 2'($urandom);
        lat      = 0;
        busy_err = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) busy_err++;
            @(negedge clk);
            lat++;
        end
        res = Out;
    endtask

    // Take the result and confirm return to IDLE with Out retained.
    task automatic release_result(input logic [15:0] held);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_xfer_in_ready", 32'(in_ready), 32'd1);
        check("post_xfer_out_valid", 32'(out_valid), 32'd0);
        check("post_xfer_out_retained", 32'(Out), 32'(held));
    endtask

    vec_t        vecs[11];
    logic [15:0] res;
    logic [15:0] held;
    logic [15:0] expv;
    logic [1:0]  rop;
    logic [15:0] ra;
    logic [3:0]  rc;
    int          lat;
    int          dly;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        busy_err  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        In        = 16'h0;
        Cnt       = 4'h0;
        Op        = 2'b00;
        out_ready = 1'b0;

        vecs[0]  = '{T_SLL, 16'h0001, 4'd5,  16'h0020};
        vecs[1]  = '{T_ROL, 16'h8001, 4'd1,  16'h0003};
        vecs[2]  = '{T_ROR, 16'h0001, 4'd4,  16'h1000};
        vecs[3]  = '{T_SRL, 16'h8000, 4'd15, 16'h0001};
        vecs[4]  = '{T_SRL, 16'hFFFF, 4'd8,  16'h00FF};
        vecs[5]  = '{T_ROL, 16'hBEEF, 4'd0,  16'hBEEF};
        vecs[6]  = '{T_SLL, 16'hFFFF, 4'd15, 16'h8000};
        vecs[7]  = '{T_ROR, 16'h1234, 4'd8,  16'h3412};
        vecs[8]  = '{T_ROL, 16'h1234, 4'd4,  16'h2341};
        vecs[9]  = '{T_SRL, 16'h1234, 4'd0,  16'h1234};
        vecs[10] = '{T_ROR, 16'h8001, 4'd15, 16'h0003};

        // Reset state.
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", 32'(Out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].c, res, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_out", i), 32'(res), 32'(vecs[i].exp));
            check($sformatf("vec%0d_busy_in_ready", i), 32'(busy_err), 32'd0);
            release_result(res);
        end

        // Backpressure: hold 10 cycles while a new request is offered.
        do_op(T_SLL, 16'h00F0, 4'd3, held, lat);
        check("bp_out", 32'(held), 32'h0780);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            In       = 16'($urandom);
            Cnt      = 4'($urandom);
            Op       = 2'($urandom);
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_out", i), 32'(Out), 32'(held));
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_result(held);
        @(negedge clk);
        check("bp_idle_hold_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of SHIFT.
        In       = 16'hA5A5;
        Cnt      = 4'd3;
        Op       = T_ROL;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(Out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        dly = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) dly++;
        end
        check("midrst_no_result", 32'(dly), 32'd0);
        do_op(T_SLL, 16'h0003, 4'd2, res, lat);
        check("midrst_next_latency", 32'(lat), 32'd4);
        check("midrst_next_out", 32'(res), 32'h000C);
        release_result(res);

        // Randomized ops against the reference model, with random consumer stalls.
        for (int i = 0; i < 150; i++) begin
            rop  = 2'($urandom);
            ra   = 16'($urandom);
            rc   = 4'($urandom);
            expv = ref_model(rop, ra, rc);
            do_op(rop, ra, rc, res, lat);
            check($sformatf("rnd%0d_out op=%0d a=%h c=%0d", i, rop, ra, rc), 32'(res), 32'(expv));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
            dly = $urandom_range(0, 3);
            for (int j = 0; j < dly; j++) begin
                @(negedge clk);
                if (Out !== expv || !out_valid) begin
                    check($sformatf("rnd%0d_stall_hold", i), 32'(Out), 32'(expv));
                end
            end
            release_result(expv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
